writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 70 +++++++
 tb/tb_writeback.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// writeback: commit stage holding the GPR file, committed PSRs, retired counter
// and the r15 redirect pulse; read ports bypass the committing write.
module writeback (
   input  logic        clk,
   input  logic        Nrst,
   input  logic        stall,
   input  logic        inbubble,
   input  logic        write_reg,
   input  logic [3:0]  write_num,
   input  logic [31:0] write_data,
   input  logic [31:0] incpsr,
   input  logic [31:0] inspsr,
   input  logic [3:0]  rd_num0,
   input  logic [3:0]  rd_num1,
   input  logic [3:0]  rd_num2,
   output logic [31:0] rd_data0,
   output logic [31:0] rd_data1,
   output logic [31:0] rd_data2,
   output logic [31:0] cpsr,
   output logic [31:0] spsr,
   output logic        jmp,
   output logic [31:0] jmppc,
   output logic [31:0] retired
);
   logic        commit, wr_en, jmp_d, jmp_q;
   logic [31:0] gpr_q [16];
   logic [31:0] gpr_d [16];
   logic [31:0] cpsr_q, cpsr_d, spsr_q, spsr_d, retired_q, retired_d, jmppc_q, jmppc_d;

   assign commit    = !stall && !inbubble;
   assign wr_en     = commit && write_reg;
   assign jmp_d     = wr_en && (write_num == 4'hF);
   assign cpsr_d    = commit ? incpsr : cpsr_q;
   assign spsr_d    = commit ? inspsr : spsr_q;
   assign retired_d = commit ? retired_q + 32'd1 : retired_q;
   assign jmppc_d   = jmp_d ? {write_data[31:2], 2'b00} : jmppc_q;

   always_comb begin
      gpr_d = gpr_q;
      if (wr_en) gpr_d[write_num] = write_data;
   end

   // jmp_q reloads every cycle, so it stays a one-cycle pulse even across a stall
   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         gpr_q     <= '{default: 32'h0};
         cpsr_q    <= 32'h000000D3;
         spsr_q    <= '0;
         retired_q <= '0;
         jmp_q     <= 1'b0;
         jmppc_q   <= '0;
      end else begin
         gpr_q     <= gpr_d;
         cpsr_q    <= cpsr_d;
         spsr_q    <= spsr_d;
         retired_q <= retired_d;
         jmp_q     <= jmp_d;
         jmppc_q   <= jmppc_d;
      end
   end

   assign rd_data0 = (wr_en && write_num == rd_num0) ? write_data : gpr_q[rd_num0];
   assign rd_data1 = (wr_en && write_num == rd_num1) ? write_data : gpr_q[rd_num1];
   assign rd_data2 = (wr_en && write_num == rd_num2) ? write_data : gpr_q[rd_num2];
   assign cpsr     = cpsr_q;
   assign spsr     = spsr_q;
   assign retired  = retired_q;
   assign jmp      = jmp_q;
   assign jmppc    = jmppc_q;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed vector table, hand-written corner sequences and a
// randomized run against a simple array-based model of the commit stage.
module tb_writeback;
   logic        clk, Nrst, stall, inbubble, write_reg, jmp;
   logic [3:0]  write_num, rd_num0, rd_num1, rd_num2;
   logic [31:0] write_data, incpsr, inspsr, rd_data0, rd_data1, rd_data2;
   logic [31:0] cpsr, spsr, jmppc, retired;
   int checks = 0, failures = 0;

   writeback dut (
      .clk(clk), .Nrst(Nrst), .stall(stall), .inbubble(inbubble),
      .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
      .incpsr(incpsr), .inspsr(inspsr),
      .rd_num0(rd_num0), .rd_num1(rd_num1), .rd_num2(rd_num2),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .cpsr(cpsr), .spsr(spsr), .jmp(jmp), .jmppc(jmppc), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st, bub, wr;
      logic [3:0]  num;
      logic [31:0] data, icpsr;
      logic [3:0]  rn1;
      logic [31:0] e_rd;
      logic [31:0] e_ret;
      logic        e_jmp;
      logic [31:0] e_jmppc, e_cpsr;
   } vec_t;

   vec_t vecs [10];

   logic [31:0] m_gpr [16];
   logic [31:0] m_cpsr, m_spsr, m_ret, m_jmppc;
   logic        m_jmp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic bub, input logic wr, input logic [3:0] num,
                        input logic [31:0] data, input logic [31:0] ic, input logic [31:0] is);
      stall = st; inbubble = bub; write_reg = wr; write_num = num;
      write_data = data; incpsr = ic; inspsr = is;
   endtask

   task automatic do_reset();
      @(negedge clk);
      Nrst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      Nrst = 1'b1;
      for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
      m_cpsr = 32'h000000D3; m_spsr = 32'h0; m_ret = 32'h0; m_jmp = 1'b0; m_jmppc = 32'h0;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] rn);
      if (!stall && !inbubble && write_reg && write_num == rn) return write_data;
      return m_gpr[rn];
   endfunction

   initial begin
      Nrst = 1'b1;
      rd_num0 = 4'h0; rd_num1 = 4'h0; rd_num2 = 4'h0;
      drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      //            st    bub   wr    num   data          icpsr         rn1   e_rd          e_ret  e_jmp e_jmppc       e_cpsr
      vecs[0] = '{1'b0, 1'b0, 1'b1, 4'h3, 32'h12345678, 32'h600000D3, 4'h3, 32'h12345678, 32'd1, 1'b0, 32'h0,        32'h600000D3};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 4'h3, 32'h0,        32'h000000D3, 4'h3, 32'h12345678, 32'd2, 1'b0, 32'h0,        32'h000000D3};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 4'h4, 32'hDEADBEEF, 32'hF00000D3, 4'h4, 32'h0,        32'd2, 1'b0, 32'h0,        32'h000000D3};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 4'h4, 32'hDEADBEEF, 32'hF00000D3, 4'h4, 32'hDEADBEEF, 32'd3, 1'b0, 32'h0,        32'hF00000D3};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 4'h5, 32'hAAAA5555, 32'h0,        4'h5, 32'h0,        32'd3, 1'b0, 32'h0,        32'hF00000D3};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 4'hF, 32'h00001007, 32'h200000D3, 4'h4, 32'hDEADBEEF, 32'd4, 1'b1, 32'h00001004, 32'h200000D3};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h200000D3, 4'hF, 32'h00001007, 32'd5, 1'b0, 32'h00001004, 32'h200000D3};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 4'hF, 32'h00002000, 32'h0,        4'hF, 32'h00001007, 32'd5, 1'b0, 32'h00001004, 32'h200000D3};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 4'hF, 32'h0000300B, 32'h200000D3, 4'hF, 32'h0000300B, 32'd6, 1'b1, 32'h00003008, 32'h200000D3};
      vecs[9] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        4'hF, 32'h0000300B, 32'd6, 1'b0, 32'h00003008, 32'h200000D3};

      do_reset();
      for (int r = 0; r < 16; r++) begin
         rd_num0 = 4'(r);
         #1 chk($sformatf("reset_r%0d", r), rd_data0, 32'h0);
      end
      chk("reset_cpsr", cpsr, 32'h000000D3);
      chk("reset_spsr", spsr, 32'h0);
      chk("reset_retired", retired, 32'h0);
      chk("reset_jmp", {31'h0, jmp}, 32'h0);
      chk("reset_jmppc", jmppc, 32'h0);

      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         drive(vecs[v].st, vecs[v].bub, vecs[v].wr, vecs[v].num, vecs[v].data, vecs[v].icpsr, 32'h0);
         rd_num1 = vecs[v].rn1;
         #1 chk($sformatf("vec%0d_rd1", v), rd_data1, vecs[v].e_rd);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_retired", v), retired, vecs[v].e_ret);
         chk($sformatf("vec%0d_jmp", v), {31'h0, jmp}, {31'h0, vecs[v].e_jmp});
         chk($sformatf("vec%0d_jmppc", v), jmppc, vecs[v].e_jmppc);
         chk($sformatf("vec%0d_cpsr", v), cpsr, vecs[v].e_cpsr);
      end

      // retired wrap: preload near the top with the pipeline stalled
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      force dut.retired_q = 32'hFFFFFFFF;
      @(posedge clk);
      #1 release dut.retired_q;
      chk("wrap_preload", retired, 32'hFFFFFFFF);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 4'h6, 32'h1, 32'h0, 32'h0);
      @(posedge clk);
      #1 chk("wrap_bubble", retired, 32'hFFFFFFFF);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 4'h6, 32'h1, 32'h0, 32'h0);
      @(posedge clk);
      #1 chk("wrap_zero", retired, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1 chk("wrap_one", retired, 32'h1);

      // reset asserted in the same cycle as an r15 commit
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h00004444, 32'h0, 32'h0);
      #2 Nrst = 1'b0;
      @(posedge clk);
      #1 chk("rstmid_jmp", {31'h0, jmp}, 32'h0);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      Nrst = 1'b1;
      rd_num0 = 4'hF;
      #1 chk("rstmid_r15", rd_data0, 32'h0);
      chk("rstmid_retired", retired, 32'h0);
      @(posedge clk);
      #1 chk("rstmid_jmp_after", {31'h0, jmp}, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 4'h2, 32'h00000055, 32'h0, 32'h0);
      @(posedge clk);
      #1 chk("rstmid_first_commit", retired, 32'h1);

      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic cm;
         @(negedge clk);
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
               4'($urandom_range(0, 15)), $urandom, $urandom, $urandom);
         rd_num0 = 4'($urandom_range(0, 15));
         rd_num1 = ($urandom_range(0, 3) == 0) ? rd_num0 : 4'($urandom_range(0, 15));
         rd_num2 = ($urandom_range(0, 3) == 0) ? write_num : 4'($urandom_range(0, 15));
         #1;
         chk("rand_rd0", rd_data0, m_read(rd_num0));
         chk("rand_rd1", rd_data1, m_read(rd_num1));
         chk("rand_rd2", rd_data2, m_read(rd_num2));
         cm = !stall && !inbubble;
         m_jmp = cm && write_reg && write_num == 4'hF;
         if (m_jmp) m_jmppc = write_data & 32'hFFFFFFFC;
         if (cm) begin
            m_cpsr = incpsr; m_spsr = inspsr; m_ret = m_ret + 32'd1;
            if (write_reg) m_gpr[write_num] = write_data;
         end
         @(posedge clk);
         #1;
         chk("rand_cpsr", cpsr, m_cpsr);
         chk("rand_spsr", spsr, m_spsr);
         chk("rand_retired", retired, m_ret);
         chk("rand_jmp", {31'h0, jmp}, {31'h0, m_jmp});
         chk("rand_jmppc", jmppc, m_jmppc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
